// File: rtl/arm_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and width defaults.
package arm_pkg;

    localparam int unsigned AddrWidthDefault = 32;
    localparam int unsigned DataWidthDefault = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusyI = 2'b01,
        StBusyD = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; a bounded streak counter lets a waiting fetch through.
module mem_arbiter
    import arm_pkg::*;
#(
    parameter int unsigned AW          = AddrWidthDefault,
    parameter int unsigned DW          = DataWidthDefault,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IReady,
    output logic [DW-1:0] IRData,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic          DReady,
    output logic [DW-1:0] DRData,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemReady,
    output logic          StallF,
    output logic          StallM
);

    localparam logic [2:0] StreakMax = 3'(MAX_DSTREAK);

    arb_state_t    state_q, state_d;
    logic [2:0]    streak_q, streak_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;

    // Next-state, grant decision and completion handshake.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        IReady      = 1'b0;
        DReady      = 1'b0;
        IRData      = irdata_q;
        DRData      = drdata_q;

        unique case (state_q)
            StIdle: begin
                // A saturated streak with a waiting fetch hands the slot to the fetch.
                if (DReq && !(IReq && streak_q == StreakMax)) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DWe;
                    mem_addr_d  = DAddr;
                    mem_wdata_d = DWData;
                    if (!IReq) begin
                        streak_d = 3'd0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 3'd1;
                    end
                end else if (IReq) begin
                    state_d     = StBusyI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IAddr;
                    mem_wdata_d = '0;
                    streak_d    = 3'd0;
                end
            end
            StBusyI: begin
                if (MemReady) begin
                    IReady    = 1'b1;
                    IRData    = MemRData;
                    irdata_d  = MemRData;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StBusyD: begin
                if (MemReady) begin
                    DReady    = 1'b1;
                    DRData    = MemRData;
                    drdata_d  = MemRData;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, streak, memory-side and capture registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            streak_q    <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign StallF   = IReq & ~IReady;
    assign StallM   = DReq & ~DReady;

endmodule
